// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between NUM_REQ status requesters.
// Define LED_PWM_EN to gate the LED colour with a global brightness PWM.
module rgb_led_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int GAP_CYCLES  = 1_200_000,
    parameter int PWM_BITS    = 8
) (
    input  logic                   clock_12mhz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_color,
    input  logic [PWM_BITS-1:0]    brightness,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   led_red,
    output logic                   led_green,
    output logic                   led_blue
);

    localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W_RAW = $clog2(GAP_CYCLES + 1);
    localparam int GAP_W     = (GAP_W_RAW < 1) ? 1 : GAP_W_RAW;
    localparam int PTR_W     = $clog2(NUM_REQ);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0]   PTR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [2:0]           color_q, color_d;
    logic                 busy_q, busy_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [2:0]           led_q, led_d;

    logic [2:0]           colors_s [NUM_REQ];
    logic [PTR_W-1:0]     idx_s;
    logic                 win_found_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic [2:0]           win_color_s;
    logic                 others_s;
    logic                 pwm_on_s;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            colors_s[i] = req_color[3*i +: 3];
        end
    end

    // Scan from farthest to nearest after ptr so the nearest set request wins.
    always_comb begin
        idx_s       = PTR_RESET;
        win_found_s = 1'b0;
        win_idx_s   = PTR_RESET;
        win_color_s = 3'b000;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s       = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            win_found_s = win_found_s | req[idx_s];
            win_idx_s   = req[idx_s] ? idx_s : win_idx_s;
            win_color_s = req[idx_s] ? colors_s[idx_s] : win_color_s;
        end
    end

    assign others_s = |(req & ~grant_q);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    assign pwm_on_s = (pwm_cnt_q < brightness);
`else
    logic unused_brightness_s;
    assign unused_brightness_s = ^brightness;
    assign pwm_on_s            = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        color_d = color_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_HOLD;
                    grant_d = ONE_HOT0 << win_idx_s;
                    ptr_d   = win_idx_s;
                    color_d = win_color_s;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end else begin
                    grant_d = '0;
                    color_d = 3'b000;
                    busy_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                // Early release and expiry with competition share one exit.
                if (!req[ptr_q] || ((hold_q == HOLD_LAST) && others_s)) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    busy_d  = (GAP_CYCLES != 0);
                    grant_d = '0;
                    color_d = 3'b000;
                    gap_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                color_d = 3'b000;
                busy_d  = 1'b0;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
        // LEDs track the colour being latched this edge so they align with grant.
        led_d = color_d & {3{pwm_on_s}};
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RESET;
            color_q <= 3'b000;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
            led_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            led_q   <= led_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign led_red   = led_q[2];
    assign led_green = led_q[1];
    assign led_blue  = led_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: directed scenarios plus random traffic
// compared against a countdown-based behavioural model of the arbitration rules.
module tb_rgb_led_arbiter;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_color;
    logic [7:0]  brightness;
    logic [3:0]  grant;
    logic        busy, led_red, led_green, led_blue;

    rgb_led_arbiter #(
        .NUM_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .PWM_BITS(PB)
    ) dut (
        .clock_12mhz(clk), .reset(reset), .req(req), .req_color(req_color),
        .brightness(brightness), .grant(grant), .busy(busy),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner index (-1 none), cycles left showing / dark, last winner.
    int         m_owner, m_show_left, m_dark_left, m_last, m_pwm;
    logic [2:0] m_color;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic [2:0] exp_led;
    logic [7:0] obs, exp_all;

    assign obs = {grant, busy, led_red, led_green, led_blue};

    function automatic void model_step();
        logic pwm_on;
        pwm_on = 1'b0;
        if (reset) begin
            m_owner = -1; m_show_left = 0; m_dark_left = 0;
            m_last = N - 1; m_color = 3'b000; m_pwm = 0;
        end else begin
`ifdef LED_PWM_EN
            pwm_on = (m_pwm < int'(brightness));
`else
            pwm_on = 1'b1;
`endif
            m_pwm = (m_pwm + 1) % (1 << PB);
            if (m_owner >= 0) begin
                m_show_left--;
                if (!req[m_owner] || (m_show_left == 0 && req != (4'b0001 << m_owner))) begin
                    m_owner = -1; m_color = 3'b000; m_dark_left = G;
                end else if (m_show_left == 0) begin
                    m_show_left = H;
                end
            end else if (m_dark_left > 0) begin
                m_dark_left--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (req[c]) begin
                        m_owner = c; m_last = c; m_show_left = H;
                        m_color = 3'(req_color >> (3 * c));
                        break;
                    end
                end
            end
        end
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_busy  = (m_owner >= 0) || (m_dark_left > 0);
        exp_led   = reset ? 3'b000 : (m_color & {3{pwm_on}});
        exp_all   = {exp_grant, exp_busy, exp_led};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'($urandom); req_color = 12'($urandom); brightness = 8'($urandom);
        tick();
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_values: got %b want 00000000", obs); end
        reset = 1'b0; req = 4'b0010;
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin n_fail++; $display("FAIL reset_pre_grant: got %b want 0010", grant); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_in_hold: got %b want 00000000", obs); end
        reset = 1'b0; req = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_winner: got %b want 0001", grant); end
        n_checks++;
        if (obs !== exp_all) begin n_fail++; $display("FAIL reset_model: got %b want %b", obs, exp_all); end
    endtask

    task automatic test_single();
        logic [3:0] want_g [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic       want_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int red_cnt;
        red_cnt = 0;
        do_reset();
        req_color = 12'b000_000_100_000; brightness = 8'hFF; req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) req = 4'b0000;
            red_cnt += int'(led_red);
            n_checks++;
            if (grant !== want_g[i] || busy !== want_b[i]) begin
                n_fail++; $display("FAIL single cyc%0d: got g=%b b=%b want g=%b b=%b", i, grant, busy, want_g[i], want_b[i]);
            end
            n_checks++;
            if (obs !== exp_all) begin n_fail++; $display("FAIL single_model cyc%0d: got %b want %b", i, obs, exp_all); end
        end
        n_checks++;
        if (red_cnt != 2) begin n_fail++; $display("FAIL single_red_cycles: got %0d want 2", red_cnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want_g;
        do_reset();
        req_color = 12'($urandom); brightness = 8'hFF; req = 4'b1111;
        for (int i = 0; i < 32; i++) begin
            tick();
            want_g = ((i % 7) < 4) ? (4'b0001 << ((i / 7) % 4)) : 4'b0000;
            n_checks++;
            if (grant !== want_g || busy !== ((i % 7) < 6)) begin
                n_fail++; $display("FAIL round_robin cyc%0d: got g=%b b=%b want g=%b b=%b", i, grant, busy, want_g, (i % 7) < 6);
            end
            n_checks++;
            if (obs !== exp_all) begin n_fail++; $display("FAIL rr_model cyc%0d: got %b want %b", i, obs, exp_all); end
        end
    endtask

    task automatic test_extension();
        bit saw_gap, saw_g0;
        saw_gap = 1'b0; saw_g0 = 1'b0;
        do_reset();
        req_color = 12'($urandom); brightness = 8'hFF; req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0100 || busy !== 1'b1) begin
                n_fail++; $display("FAIL extension_hold cyc%0d: got g=%b b=%b want g=0100 b=1", i, grant, busy);
            end
        end
        req = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant === 4'b0000 && busy === 1'b1) saw_gap = 1'b1;
            if (grant === 4'b0001 && saw_gap) saw_g0 = 1'b1;
            n_checks++;
            if (obs !== exp_all) begin n_fail++; $display("FAIL extension_model cyc%0d: got %b want %b", i, obs, exp_all); end
        end
        n_checks++;
        if (!(saw_gap && saw_g0)) begin n_fail++; $display("FAIL extension_handover: got gap=%0b grant0=%0b want 1 1", saw_gap, saw_g0); end
    endtask

    task automatic test_color_freeze();
        do_reset();
        brightness = 8'hFF; req_color = 12'b000_010_000_000; req = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 1) req_color = 12'b000_101_111_111;
            n_checks++;
            if ({led_red, led_green, led_blue} !== 3'b010) begin
                n_fail++; $display("FAIL color_freeze cyc%0d: got %b%b%b want 010", i, led_red, led_green, led_blue);
            end
        end
    endtask

    task automatic test_pwm();
        int on_cnt [3];
        int want_on;
        logic [7:0] levels [2] = '{8'd64, 8'd0};
        do_reset();
        req_color = 12'b000_000_000_111; req = 4'b0001;
        for (int l = 0; l < 2; l++) begin
            brightness = levels[l];
            for (int i = 0; i < 3; i++) tick();
            on_cnt = '{0, 0, 0};
            for (int i = 0; i < 256; i++) begin
                tick();
                on_cnt[0] += int'(led_red); on_cnt[1] += int'(led_green); on_cnt[2] += int'(led_blue);
                n_checks++;
                if (obs !== exp_all) begin n_fail++; $display("FAIL pwm_model b=%0d cyc%0d: got %b want %b", levels[l], i, obs, exp_all); end
            end
`ifdef LED_PWM_EN
            want_on = int'(levels[l]);
`else
            want_on = 256;
`endif
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (on_cnt[c] != want_on) begin
                    n_fail++; $display("FAIL pwm_duty b=%0d led%0d: got %0d want %0d", levels[l], c, on_cnt[c], want_on);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(59) == 0);
            if ($urandom_range(3) == 0) req = 4'($urandom);
            if ($urandom_range(7) == 0) req_color = 12'($urandom);
            if ($urandom_range(15) == 0) brightness = 8'($urandom);
            tick();
            n_checks++;
            if (obs !== exp_all) begin n_fail++; $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_all); end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 4'b0000; req_color = 12'h000; brightness = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_extension();
        test_color_freeze();
        test_pwm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
